// File: rtl/shift_sched_pkg.sv
// Shared types for the shift scheduler: opcodes, FSM states and opcode helpers.
package shift_sched_pkg;

    typedef enum logic [2:0] {
        OP_LOAD = 3'b000,
        OP_LSL  = 3'b001,
        OP_LSR  = 3'b010,
        OP_ASL  = 3'b011,
        OP_ASR  = 3'b100,
        OP_ROL  = 3'b101,
        OP_ROR  = 3'b110,
        OP_RSVD = 3'b111
    } op_t;

    localparam op_t OP_RESERVED = OP_RSVD;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Commands that finish without visiting SHIFT.
    function automatic logic is_direct(input op_t op, input logic amt_zero);
        return (op == OP_LOAD) || (op == OP_RESERVED) || amt_zero;
    endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit-position shift of the shared register; combinational, one instance.
module shift_step
    import shift_sched_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  op_t              i_op,
    input  logic [WIDTH-1:0] i_q,
    output logic [WIDTH-1:0] o_q
);

    always_comb begin
        o_q = i_q;
        case (i_op)
            OP_LSL, OP_ASL: o_q = {i_q[WIDTH-2:0], 1'b0};
            OP_LSR:         o_q = {1'b0, i_q[WIDTH-1:1]};
            OP_ASR:         o_q = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
            OP_ROL:         o_q = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
            OP_ROR:         o_q = {i_q[0], i_q[WIDTH-1:1]};
            default:        o_q = i_q;
        endcase
    end

endmodule

// File: rtl/shift_scheduler.sv
// Two-requester round-robin scheduler driving one shared shift register.
// Define SHIFT_SCHED_ERR_EN to flag reserved opcodes on Rsp_Err.
//
// state    | meaning
// ST_IDLE  | arbitrate and accept one command
// ST_SHIFT | move Q one bit per cycle while the counter runs down
// ST_RESP  | hold the response until the consumer takes it
module shift_scheduler
    import shift_sched_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Req0_Valid,
    output logic             Req0_Ready,
    input  logic [2:0]       Req0_Op,
    input  logic [AMT_W-1:0] Req0_Amt,
    input  logic [WIDTH-1:0] Req0_Data,
    input  logic             Req1_Valid,
    output logic             Req1_Ready,
    input  logic [2:0]       Req1_Op,
    input  logic [AMT_W-1:0] Req1_Amt,
    input  logic [WIDTH-1:0] Req1_Data,
    output logic             Rsp_Valid,
    input  logic             Rsp_Ready,
    output logic             Rsp_Id,
    output logic             Rsp_Err,
    output logic [WIDTH-1:0] Q
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_step;
    logic [AMT_W-1:0] r_cnt;
    op_t              r_op;
    logic             r_id;
    logic             r_last;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    op_t              w_sel_op;
    logic [AMT_W-1:0] w_sel_amt;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_direct;

    assign w_accept   = w_grant0 | w_grant1;
    assign w_sel_op   = op_t'(w_grant1 ? Req1_Op : Req0_Op);
    assign w_sel_amt  = w_grant1 ? Req1_Amt : Req0_Amt;
    assign w_sel_data = w_grant1 ? Req1_Data : Req0_Data;
    assign w_direct   = is_direct(w_sel_op, (w_sel_amt == '0));

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = w_direct ? ST_RESP : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == AMT_W'(1)) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (Rsp_Ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // On a tie the grant goes to whoever was not served last.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r_state == ST_IDLE) begin
            if (Req0_Valid && Req1_Valid) begin
                w_grant0 = r_last;
                w_grant1 = ~r_last;
            end else begin
                w_grant0 = Req0_Valid;
                w_grant1 = Req1_Valid;
            end
        end
        Req0_Ready = w_grant0;
        Req1_Ready = w_grant1;
        Rsp_Valid  = (r_state == ST_RESP);
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_q    <= '0;
            r_cnt  <= '0;
            r_op   <= OP_LOAD;
            r_id   <= 1'b0;
            r_last <= 1'b1;
        end else begin
            if (w_accept) begin
                r_op <= w_sel_op;
                r_id <= w_grant1;
                if (w_sel_op == OP_LOAD) begin
                    r_q <= w_sel_data;
                end
                if (!w_direct) begin
                    r_cnt <= w_sel_amt;
                end
            end
            if (r_state == ST_SHIFT) begin
                r_q   <= w_q_step;
                r_cnt <= r_cnt - 1'b1;
            end
            if ((r_state == ST_RESP) && Rsp_Ready) begin
                r_last <= r_id;
            end
        end
    end

`ifdef SHIFT_SCHED_ERR_EN
    logic r_err;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= (w_sel_op == OP_RESERVED);
        end
    end

    assign Rsp_Err = r_err;
`else
    assign Rsp_Err = 1'b0;
`endif

    shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .i_op (r_op),
        .i_q  (r_q),
        .o_q  (w_q_step)
    );

    assign Q      = r_q;
    assign Rsp_Id = r_id;

endmodule

// File: tb/tb_shift_scheduler.sv
// Bench for shift_scheduler: directed scenarios plus random commands against a shift model.
module tb_shift_scheduler;

    localparam int W  = 4;
    localparam int AW = 2;

    logic          Clock = 1'b0;
    logic          Reset_n = 1'b0;
    logic          Req0_Valid = 1'b0;
    logic          Req0_Ready;
    logic [2:0]    Req0_Op = '0;
    logic [AW-1:0] Req0_Amt = '0;
    logic [W-1:0]  Req0_Data = '0;
    logic          Req1_Valid = 1'b0;
    logic          Req1_Ready;
    logic [2:0]    Req1_Op = '0;
    logic [AW-1:0] Req1_Amt = '0;
    logic [W-1:0]  Req1_Data = '0;
    logic          Rsp_Valid;
    logic          Rsp_Ready = 1'b0;
    logic          Rsp_Id;
    logic          Rsp_Err;
    logic [W-1:0]  Q;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] mq = '0;

    always #5 Clock = ~Clock;

    shift_scheduler #(.WIDTH(W), .AMT_W(AW)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .Req0_Valid(Req0_Valid), .Req0_Ready(Req0_Ready), .Req0_Op(Req0_Op),
        .Req0_Amt(Req0_Amt), .Req0_Data(Req0_Data),
        .Req1_Valid(Req1_Valid), .Req1_Ready(Req1_Ready), .Req1_Op(Req1_Op),
        .Req1_Amt(Req1_Amt), .Req1_Data(Req1_Data),
        .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Id(Rsp_Id),
        .Rsp_Err(Rsp_Err), .Q(Q)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole-command result: k bit positions at once, from the opcode's definition.
    function automatic logic [W-1:0] model_next(input logic [2:0] op, input int k,
                                                input logic [W-1:0] q, input logic [W-1:0] d);
        logic [W-1:0] r;
        case (op)
            3'd0:       r = d;
            3'd1, 3'd3: r = q << k;
            3'd2:       r = q >> k;
            3'd4:       r = $signed(q) >>> k;
            3'd5:       r = (q << k) | (q >> (W - k));
            3'd6:       r = (q >> k) | (q << (W - k));
            default:    r = q;
        endcase
        return r;
    endfunction

    task automatic drive_req(input int n, input logic v, input logic [2:0] op,
                             input int amt, input logic [W-1:0] d);
        if (n == 0) begin
            Req0_Valid = v; Req0_Op = op; Req0_Amt = AW'(amt); Req0_Data = d;
        end else begin
            Req1_Valid = v; Req1_Op = op; Req1_Amt = AW'(amt); Req1_Data = d;
        end
    endtask

    function automatic logic ready_of(input int n);
        return (n == 0) ? Req0_Ready : Req1_Ready;
    endfunction

    // Issue one command from IDLE and follow it through its response handshake.
    task automatic do_cmd(input int n, input logic [2:0] op, input int amt, input logic [W-1:0] d,
                          input int hold, input bit pre_ready, input bit poke);
        int waits;
        int lat;
        int exp_lat;
        logic exp_err;
        logic [W-1:0] exp_q;
        exp_q   = model_next(op, amt, mq, d);
        exp_lat = (op == 3'd0 || op == 3'd7 || amt == 0) ? 0 : amt;
`ifdef SHIFT_SCHED_ERR_EN
        exp_err = (op == 3'd7);
`else
        exp_err = 1'b0;
`endif
        drive_req(n, 1'b1, op, amt, d);
        #1;
        waits = 0;
        while (!ready_of(n) && waits < 20) begin
            @(posedge Clock); #2;
            waits++;
        end
        chk("grant_immediate", waits, 0);
        chk("ready_exclusive", {31'd0, Req0_Ready & Req1_Ready}, 0);
        @(posedge Clock); #1;
        drive_req(n, 1'b0, 3'd0, 0, '0);
        Rsp_Ready = pre_ready;
        lat = 0;
        while (!Rsp_Valid && lat < 20) begin
            @(posedge Clock); #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("rsp_id", {31'd0, Rsp_Id}, n);
        chk("rsp_err", {31'd0, Rsp_Err}, {31'd0, exp_err});
        chk("q_result", {28'd0, Q}, {28'd0, exp_q});
        mq = exp_q;
        if (!pre_ready) begin
            if (poke) drive_req(1 - n, 1'b1, 3'd0, 0, ~exp_q);
            repeat (hold) begin
                @(posedge Clock); #1;
                chk("hold_valid", {31'd0, Rsp_Valid}, 1);
                chk("hold_id", {31'd0, Rsp_Id}, n);
                chk("hold_q", {28'd0, Q}, {28'd0, exp_q});
                chk("hold_no_ready", {31'd0, Req0_Ready | Req1_Ready}, 0);
            end
            if (poke) drive_req(1 - n, 1'b0, 3'd0, 0, '0);
            Rsp_Ready = 1'b1;
        end
        @(posedge Clock); #1;
        Rsp_Ready = 1'b0;
        chk("rsp_taken", {31'd0, Rsp_Valid}, 0);
        chk("q_holds", {28'd0, Q}, {28'd0, mq});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] d0 [3];
        logic [W-1:0] d1 [3];
        int gseq [6];
        int c0;
        int c1;
        int ng;
        int last_g;
        bit both;
        bit id_bad;

        // Reset state
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_q", {28'd0, Q}, 0);
        chk("rst_valid", {31'd0, Rsp_Valid}, 0);
        chk("rst_id", {31'd0, Rsp_Id}, 0);
        chk("rst_err", {31'd0, Rsp_Err}, 0);
        chk("rst_ready", {30'd0, Req1_Ready, Req0_Ready}, 0);
        Reset_n = 1'b1;
        @(posedge Clock); #1;

        do_cmd(0, 3'd0, 0, 4'b1000, 0, 1'b1, 1'b0);
        do_cmd(0, 3'd6, 2, 4'b0000, 2, 1'b0, 1'b0);
        chk("ror2_q", {28'd0, Q}, 32'b0010);

        do_cmd(1, 3'd0, 0, 4'b1011, 0, 1'b0, 1'b0);
        do_cmd(1, 3'd4, 3, 4'b0000, 1, 1'b0, 1'b0);
        chk("asr3_q", {28'd0, Q}, 32'b1111);
        do_cmd(1, 3'd0, 0, 4'b1001, 0, 1'b1, 1'b0);
        do_cmd(1, 3'd1, 1, 4'b0000, 0, 1'b1, 1'b0);
        chk("lsl1_q", {28'd0, Q}, 32'b0010);

        do_cmd(0, 3'd0, 0, 4'b0110, 0, 1'b1, 1'b0);
        do_cmd(0, 3'd2, 3, 4'b0000, 5, 1'b0, 1'b1);
        chk("lsr3_q", {28'd0, Q}, 32'b0000);

        do_cmd(0, 3'd0, 0, 4'b0001, 0, 1'b1, 1'b0);
        do_cmd(0, 3'd7, 1, 4'b1110, 1, 1'b0, 1'b0);
        chk("rsvd_q", {28'd0, Q}, 32'b0001);

        for (int i = 0; i < 40; i++) begin
            do_cmd(int'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   int'($urandom_range(0, 3)), W'($urandom), int'($urandom_range(0, 3)),
                   bit'($urandom_range(0, 1)), 1'b0);
        end

        // Reset in the middle of a shift aborts it
        do_cmd(0, 3'd0, 0, 4'b1011, 0, 1'b1, 1'b0);
        drive_req(0, 1'b1, 3'd5, 3, '0);
        #1;
        chk("rol_grant", {31'd0, Req0_Ready}, 1);
        @(posedge Clock); #1;
        drive_req(0, 1'b0, 3'd0, 0, '0);
        @(posedge Clock); #1;
        chk("rol_one_step", {28'd0, Q}, 32'b0111);
        Reset_n = 1'b0;
        @(posedge Clock); #1;
        Reset_n = 1'b1;
        mq = '0;
        chk("abort_q", {28'd0, Q}, 0);
        chk("abort_valid", {31'd0, Rsp_Valid}, 0);
        Rsp_Ready = 1'b1;
        repeat (4) begin
            @(posedge Clock); #1;
            chk("abort_no_rsp", {31'd0, Rsp_Valid}, 0);
        end

        // Both requesters contend continuously
        d0 = '{4'd1, 4'd2, 4'd3};
        d1 = '{4'd9, 4'd10, 4'd11};
        c0 = 0; c1 = 0; ng = 0; last_g = -1; both = 1'b0; id_bad = 1'b0;
        drive_req(0, 1'b1, 3'd0, 0, d0[0]);
        drive_req(1, 1'b1, 3'd0, 0, d1[0]);
        for (int cy = 0; cy < 60 && ng < 6; cy++) begin
            #1;
            if (Req0_Ready && Req1_Ready) both = 1'b1;
            if (Rsp_Valid && last_g >= 0 && Rsp_Id !== last_g[0]) id_bad = 1'b1;
            if (Req0_Ready) begin
                gseq[ng] = 0; ng++; c0++; last_g = 0;
            end else if (Req1_Ready) begin
                gseq[ng] = 1; ng++; c1++; last_g = 1;
            end
            @(posedge Clock); #1;
            drive_req(0, c0 < 3, 3'd0, 0, (c0 < 3) ? d0[c0] : 4'd0);
            drive_req(1, c1 < 3, 3'd0, 0, (c1 < 3) ? d1[c1] : 4'd0);
        end
        chk("tie_grants", ng, 6);
        for (int i = 0; i < 6; i++) chk("tie_order", gseq[i], i % 2);
        chk("tie_exclusive", {31'd0, both}, 0);
        chk("tie_rsp_id", {31'd0, id_bad}, 0);
        @(posedge Clock); #1;
        chk("tie_final_q", {28'd0, Q}, 32'd11);
        Rsp_Ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
